mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the CPU instruction-fetch port (I) and the data-access port (D).
- Sits between the pipelined CPU's IF and MEM stages and the memory model or bus.
- Serialises requests, holds the memory handshake until the access completes and returns read data with a one-cycle ready pulse.
- The CPU stalls each stage while that stage's request is pending and its ready pulse has not yet arrived.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_MAX, 4, maximum consecutive D grants while I is waiting; range 1..15.
- TIMEOUT, 64, cycles of mem_req without mem_ack before abort (used only with the optional feature).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0, released synchronously by the bench.
- if_req  in  1  instruction fetch request; held with if_addr stable until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; valid in the if_ready cycle and held until the next I response.
- if_ready  out  1  one-cycle completion pulse for I.
- d_req  in  1  data request; held with d_we, d_addr and d_wdata stable until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid in the d_ready cycle and held until the next D response.
- d_ready  out  1  one-cycle completion pulse for D, for loads and stores.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack=1.
- mem_ack  in  1  memory completion; sampled only while mem_req=1.
- grant_d  out  1  1 while the current or last transaction belongs to D (debug visibility).
- err  out  1  sticky timeout flag; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset (reset=0): asynchronous. FSM goes to IDLE. All outputs 0, streak counter 0, timeout counter 0, err 0. The effect is immediate, including mid-transaction; no ready pulse is issued for an aborted access.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, request present: choose the winner. At the clock edge, register the winner's address, we and wdata onto mem_*, set mem_req=1, set grant_d, go to ACCESS.
- Arbitration order:
  - Only one port requesting: that port wins.
  - Both requesting and streak<STARVE_MAX: D wins (D holds the older instruction).
  - Both requesting and streak==STARVE_MAX: I wins.
- Streak counter:
  - Increments on each D grant made while if_req=1.
  - Clears on any I grant, and on any D grant made while if_req=0.
  - Saturates at STARVE_MAX.
- ACCESS: mem_* held stable.
  - mem_ack=1: capture mem_rdata into the granted port's rdata register, clear mem_req and mem_we, go to RESP.
  - mem_ack=0: stay in ACCESS. There is no limit unless the feature is enabled.
- RESP: pulse the granted port's ready for exactly this cycle, ignore all requests, go to IDLE. RESP is one cycle, so the requester can update req before the next arbitration.
- Stores: d_rdata is unchanged; d_ready still pulses.
- Latency: request seen at edge N → mem_req high cycle N+1 → with mem_ack in that same cycle, ready high cycle N+2. Minimum 3 cycles between consecutive grants.
- mem_ack outside ACCESS is ignored.
- A req dropped before its ready is a protocol violation; behaviour is undefined and the bench does not check it.
- if_rdata and d_rdata are never cleared except by reset.
- Addresses and data pass through unmodified; no alignment checks.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS and clears on entry to ACCESS.
  - If it reaches TIMEOUT with mem_ack still 0: drop mem_req, set err=1 (sticky until reset), go to RESP.
  - The granted port still receives its ready pulse, with rdata = 0.
- Undefined: no counter, err tied 0, ACCESS waits indefinitely.

Test Plan:
- Zero-wait fetch: if_req=1, if_addr=0x0000_0040, memory acks in the first mem_req cycle with 0x2008_0005 → mem_req high exactly 1 cycle with mem_addr=0x40, mem_we=0; if_ready pulses 2 cycles after the request edge; if_rdata=0x2008_0005.
- D store with 3 wait states: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF; ack on the 4th mem_req cycle → mem_req/mem_we/mem_wdata held 4 cycles; d_ready one pulse; d_rdata unchanged.
- Simultaneous requests: if_req and d_req rise together (load, ack reads 0x1234) → D served first (grant_d=1); the I grant starts 3 cycles later; if_ready follows d_ready by 3 cycles.
- Starvation: d_req held continuously and if_req held, STARVE_MAX=4 → grants D,D,D,D,I,D…; if_ready occurs after the 4th d_ready.
- Reset mid-access: reset=0 during ACCESS → mem_req, mem_we, if_ready, d_ready and err drop immediately; after release, a fresh if_req completes normally.
- With ARB_TIMEOUT_EN and TIMEOUT=8, memory never acks → mem_req drops after 8 cycles; err=1 and stays 1; the requester gets a ready pulse with rdata=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported unified memory between the CPU instruction-fetch
//   port (I) and the data-access port (D). One transaction is in flight at a
//   time: IDLE picks a winner, ACCESS holds the memory handshake until mem_ack,
//   RESP pulses the winner's ready for one cycle and ignores all requests so
//   the requester can update req before the next arbitration.
//
//   Arbitration: D wins ties (it holds the older instruction) unless D has
//   already been granted STARVE_MAX times in a row while I was waiting.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   Defined   - an ACCESS cycle counter aborts a transaction after TIMEOUT
//               cycles without mem_ack, sets sticky err, and still returns a
//               ready pulse to the granted port with rdata = 0.
//   Undefined - no counter, err tied 0, ACCESS waits for mem_ack forever.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   if_req/if_addr        fetch request, held until if_ready
//   if_rdata/if_ready     fetched word (held) / one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  data request, held until d_ready
//   d_rdata/d_ready       load data (held, untouched by stores) / completion
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until mem_ack
//   mem_rdata/mem_ack     memory read data / completion
//   grant_d               current or last transaction belongs to D
//   err                   sticky timeout flag
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              grant_d,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_grant_d;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_if_ready;
  logic                r_d_ready;
  logic [3:0]          r_streak;

  logic                w_grant_now;  // IDLE with a request: launch at this edge
  logic                w_pick_d;     // winner of this arbitration is D
  logic                w_done;       // ACCESS completed by mem_ack
  logic                w_tout;       // ACCESS aborted by the timeout counter
  logic [DATA_W-1:0]   w_resp_data;

`ifdef ARB_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_err;
  logic                w_tcnt_hit;

  // The counter is 0 in the first ACCESS cycle, so hitting TIMEOUT-1 means
  // mem_req has been high for TIMEOUT cycles with no ack.
  assign w_tcnt_hit = (r_tcnt == TCNT_W'(TIMEOUT - 1));
`else
  logic                w_tcnt_hit;
  logic                w_unused_timeout;

  assign w_tcnt_hit       = 1'b0;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_grant_now = 1'b0;
    w_pick_d    = 1'b0;
    w_done      = 1'b0;
    w_tout      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (if_req || d_req) begin
          w_grant_now = 1'b1;
          // Streak saturates at STREAK_MAX, so "!=" is the "<" test.
          w_pick_d    = d_req && (!if_req || (r_streak != STREAK_MAX));
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_tcnt_hit) begin
          w_tout      = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // An aborted access returns zero to the requester.
  assign w_resp_data = w_tout ? '0 : mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Memory handshake, responses, starvation streak
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_grant_d   <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
      r_streak    <= '0;
    end else begin
      // Ready is a single-cycle pulse: it is only ever set on the edge that
      // enters RESP and cleared on the edge that leaves it.
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;

      if (w_grant_now) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_pick_d & d_we;
        r_mem_addr  <= w_pick_d ? d_addr  : if_addr;
        r_mem_wdata <= w_pick_d ? d_wdata : '0;
        r_grant_d   <= w_pick_d;
        // Only D grants that leave I waiting lengthen the streak.
        if (w_pick_d && if_req) begin
          if (r_streak != STREAK_MAX) r_streak <= r_streak + 4'd1;
        end else begin
          r_streak <= '0;
        end
      end

      if (w_done || w_tout) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
        if (r_grant_d) begin
          r_d_ready <= 1'b1;
          // Stores leave the load-data register untouched.
          if (!r_mem_we) r_d_rdata <= w_resp_data;
        end else begin
          r_if_ready <= 1'b1;
          r_if_rdata <= w_resp_data;
        end
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_grant_now)                             r_tcnt <= '0;
      else if ((r_state == S_ACCESS) && !w_tcnt_hit) r_tcnt <= r_tcnt + 1'b1;
      if (w_tout) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign grant_d   = r_grant_d;
  assign if_rdata  = r_if_rdata;
  assign if_ready  = r_if_ready;
  assign d_rdata   = r_d_rdata;
  assign d_ready   = r_d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Inputs change and outputs are sampled
//   on the falling clock edge; the design acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        grant_d;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant_d(grant_d), .err(err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; mem_rdata = 0; mem_ack = 0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %h want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %h want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    checks++; if ({if_ready, d_ready, grant_d, err} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {if_ready, d_ready, grant_d, err}); end
    checks++; if ({if_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", {if_rdata, d_rdata}); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %h want 0", mem_req); end
  endtask

  task automatic test_fetch_zero_wait();
    if_req = 1; if_addr = 32'h0000_0040;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch_mem_req: got %h want 1", mem_req); end
    checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL fetch_mem_addr: got %h want 40", mem_addr); end
    checks++; if ({mem_we, grant_d, if_ready} !== 3'b000) begin errors++; $display("FAIL fetch_ctrl: got %b want 000", {mem_we, grant_d, if_ready}); end
    mem_ack = 1; mem_rdata = 32'h2008_0005;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_req_drop: got %h want 0", mem_req); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready: got %h want 1", if_ready); end
    checks++; if (if_rdata !== 32'h2008_0005) begin errors++; $display("FAIL fetch_rdata: got %h want 20080005", if_rdata); end
    mem_ack = 0; mem_rdata = 0; if_req = 0;
    @(negedge clk);
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL fetch_ready_pulse: got %h want 0", if_ready); end
    checks++; if (if_rdata !== 32'h2008_0005) begin errors++; $display("FAIL fetch_rdata_hold: got %h want 20080005", if_rdata); end
  endtask

  task automatic test_store_wait();
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'h55AA_55AA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({mem_req, mem_we, grant_d, d_ready} !== 4'b1110) begin errors++; $display("FAIL store_ctrl_%0d: got %b want 1110", i, {mem_req, mem_we, grant_d, d_ready}); end
      checks++; if ({mem_addr, mem_wdata} !== {32'h100, 32'hDEAD_BEEF}) begin errors++; $display("FAIL store_bus_%0d: got %h %h want 100 deadbeef", i, mem_addr, mem_wdata); end
      if (i == 3) mem_ack = 1;
    end
    @(negedge clk);
    checks++; if ({mem_req, mem_we, d_ready} !== 3'b001) begin errors++; $display("FAIL store_done: got %b want 001", {mem_req, mem_we, d_ready}); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata_kept: got %h want 0", d_rdata); end
    d_req = 0; d_we = 0; mem_ack = 0;
    @(negedge clk);
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL store_ready_pulse: got %h want 0", d_ready); end
  endtask

  task automatic test_simultaneous();
    if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h200;
    @(negedge clk);
    checks++; if ({mem_req, grant_d} !== 2'b11) begin errors++; $display("FAIL sim_d_first: got %b want 11", {mem_req, grant_d}); end
    checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL sim_d_addr: got %h want 200", mem_addr); end
    mem_ack = 1; mem_rdata = 32'h1234;
    @(negedge clk);
    checks++; if ({d_ready, if_ready} !== 2'b10) begin errors++; $display("FAIL sim_d_ready: got %b want 10", {d_ready, if_ready}); end
    checks++; if (d_rdata !== 32'h1234) begin errors++; $display("FAIL sim_d_rdata: got %h want 1234", d_rdata); end
    mem_ack = 0; d_req = 0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sim_gap: got %h want 0", mem_req); end
    @(negedge clk);
    checks++; if ({mem_req, grant_d} !== 2'b10) begin errors++; $display("FAIL sim_i_grant: got %b want 10", {mem_req, grant_d}); end
    checks++; if (mem_addr !== 32'h80) begin errors++; $display("FAIL sim_i_addr: got %h want 80", mem_addr); end
    mem_ack = 1; mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    checks++; if ({if_ready, d_ready} !== 2'b10) begin errors++; $display("FAIL sim_i_ready: got %b want 10", {if_ready, d_ready}); end
    checks++; if (if_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL sim_i_rdata: got %h want cafe0001", if_rdata); end
    mem_ack = 0; if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    logic [5:0] seq;
    logic       exp_d;
    seq = 6'b101111;  // bit g = 1: grant g goes to D
    if_req = 1; if_addr = 32'h800; d_req = 1; d_we = 0; d_addr = 32'h700;
    for (int g = 0; g < 6; g++) begin
      exp_d = seq[g];
      @(negedge clk);
      checks++; if ({mem_req, grant_d} !== {1'b1, exp_d}) begin errors++; $display("FAIL starve_grant_%0d: got %b want %b", g, {mem_req, grant_d}, {1'b1, exp_d}); end
      checks++; if (mem_addr !== (exp_d ? 32'h700 : 32'h800)) begin errors++; $display("FAIL starve_addr_%0d: got %h want %h", g, mem_addr, exp_d ? 32'h700 : 32'h800); end
      mem_ack = 1; mem_rdata = 32'h100 + g;
      @(negedge clk);
      checks++; if ({d_ready, if_ready} !== {exp_d, ~exp_d}) begin errors++; $display("FAIL starve_ready_%0d: got %b want %b", g, {d_ready, if_ready}, {exp_d, ~exp_d}); end
      mem_ack = 0;
      if (g == 5) begin if_req = 0; d_req = 0; end
      @(negedge clk);
    end
    checks++; if (if_rdata !== 32'h104) begin errors++; $display("FAIL starve_if_rdata: got %h want 104", if_rdata); end
    checks++; if (d_rdata !== 32'h105) begin errors++; $display("FAIL starve_d_rdata: got %h want 105", d_rdata); end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    if_req = 1; if_addr = 32'h400; mem_rdata = 32'hFFFF_FFFF; mem_ack = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if ({mem_req, err, if_ready} !== 3'b100) begin errors++; $display("FAIL tout_wait_%0d: got %b want 100", i, {mem_req, err, if_ready}); end
    end
    @(negedge clk);
    checks++; if ({mem_req, err, if_ready} !== 3'b011) begin errors++; $display("FAIL tout_abort: got %b want 011", {mem_req, err, if_ready}); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL tout_rdata: got %h want 0", if_rdata); end
    if_req = 0;
    repeat (3) @(negedge clk);
    checks++; if ({err, if_ready, mem_req} !== 3'b100) begin errors++; $display("FAIL tout_sticky: got %b want 100", {err, if_ready, mem_req}); end
  endtask
`else
  task automatic test_long_wait();
    d_req = 1; d_we = 0; d_addr = 32'h300; mem_ack = 0; mem_rdata = 32'h77;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (i % 20 == 19) begin
        checks++; if ({mem_req, err, d_ready} !== 3'b100) begin errors++; $display("FAIL wait_hold_%0d: got %b want 100", i, {mem_req, err, d_ready}); end
      end
    end
    mem_ack = 1;
    @(negedge clk);
    checks++; if ({d_ready, mem_req, err} !== 3'b100) begin errors++; $display("FAIL wait_done: got %b want 100", {d_ready, mem_req, err}); end
    checks++; if (d_rdata !== 32'h77) begin errors++; $display("FAIL wait_rdata: got %h want 77", d_rdata); end
    mem_ack = 0; d_req = 0;
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_access();
    d_req = 1; d_we = 1; d_addr = 32'h500; d_wdata = 32'h1111_2222;
    @(negedge clk);
    checks++; if ({mem_req, mem_we} !== 2'b11) begin errors++; $display("FAIL mid_pre: got %b want 11", {mem_req, mem_we}); end
    reset = 0;
    #1;
    checks++; if ({mem_req, mem_we, if_ready, d_ready, err, grant_d} !== 6'b0) begin errors++; $display("FAIL mid_drop: got %b want 000000", {mem_req, mem_we, if_ready, d_ready, err, grant_d}); end
    checks++; if ({d_rdata, if_rdata} !== 64'h0) begin errors++; $display("FAIL mid_rdata_clr: got %h want 0", {d_rdata, if_rdata}); end
    @(negedge clk);
    d_req = 0; d_we = 0; reset = 1;
    @(negedge clk);
    checks++; if ({mem_req, d_ready} !== 2'b00) begin errors++; $display("FAIL mid_no_ready: got %b want 00", {mem_req, d_ready}); end
    if_req = 1; if_addr = 32'h600;
    @(negedge clk);
    checks++; if ({mem_req, grant_d, mem_addr} !== {2'b10, 32'h600}) begin errors++; $display("FAIL mid_fresh_grant: got %b %h want 10 600", {mem_req, grant_d}, mem_addr); end
    mem_ack = 1; mem_rdata = 32'hABCD_0123;
    @(negedge clk);
    checks++; if ({if_ready, if_rdata} !== {1'b1, 32'hABCD_0123}) begin errors++; $display("FAIL mid_fresh_done: got %b %h want 1 abcd0123", if_ready, if_rdata); end
    mem_ack = 0; if_req = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch_zero_wait();
    test_store_wait();
    test_simultaneous();
    test_starvation();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
